// File: rtl/order_generator.sv
// Threshold trading rule on decoded market data; emits a 12-byte order
// packet (header, side, ticker, price, lot, XOR checksum) over a valid/ready byte stream.
module order_generator #(
    parameter logic [15:0] LOT      = 16'd100,
    parameter int          MAX_POS  = 1000,
    parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        packet_ready,
    input  logic [31:0] ticker,
    input  logic [31:0] timestamp,
    input  logic [23:0] ask_cents,
    input  logic [23:0] bid_cents,
    input  logic [15:0] position,
    input  logic        cfg_enable,
    input  logic [23:0] cfg_buy_limit,
    input  logic [23:0] cfg_sell_limit,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_last,
    output logic        busy,
    output logic [15:0] order_count,
    output logic [15:0] drop_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        SEND = 2'd2
    } state_t;

    localparam logic [7:0]         SIDE_BUY  = 8'h42;
    localparam logic [7:0]         SIDE_SELL = 8'h53;
    localparam logic [3:0]         LAST_IDX  = 4'd11;
    // 18-bit signed keeps pos +/- LOT free of overflow for any 16-bit LOT
    localparam logic signed [17:0] LOT_S     = 18'(LOT);
    localparam logic signed [17:0] MAX_S     = 18'(MAX_POS);

    state_t      state_q, state_d;
    logic [31:0] ticker_q, ticker_d;
    logic [31:0] timestamp_q, timestamp_d;
    logic [23:0] ask_q, ask_d;
    logic [23:0] bid_q, bid_d;
    logic [15:0] pos_q, pos_d;
    logic [7:0]  side_q, side_d;
    logic [23:0] price_q, price_d;
    logic [7:0]  csum_q, csum_d;
    logic [3:0]  byte_idx_q, byte_idx_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic        tx_valid_q, tx_valid_d;
    logic        tx_last_q, tx_last_d;
    logic        busy_q, busy_d;
    logic [15:0] order_count_q, order_count_d;
    logic [15:0] drop_count_q, drop_count_d;

    logic signed [17:0] pos_s;
    logic               buy_ok_s;
    logic               sell_ok_s;
    logic [7:0]         ord_side_s;
    logic [23:0]        ord_price_s;
    logic               unused_ts_s;

    function automatic logic [7:0] calc_checksum(input logic [7:0] side,
                                                 input logic [31:0] tkr,
                                                 input logic [23:0] price);
        return side ^ tkr[31:24] ^ tkr[23:16] ^ tkr[15:8] ^ tkr[7:0]
             ^ price[23:16] ^ price[15:8] ^ price[7:0] ^ LOT[15:8] ^ LOT[7:0];
    endfunction

    function automatic logic [7:0] pkt_byte(input logic [3:0] idx,
                                            input logic [7:0] side,
                                            input logic [31:0] tkr,
                                            input logic [23:0] price,
                                            input logic [7:0] csum);
        case (idx)
            4'd0:    return HDR_BYTE;
            4'd1:    return side;
            4'd2:    return tkr[31:24];
            4'd3:    return tkr[23:16];
            4'd4:    return tkr[15:8];
            4'd5:    return tkr[7:0];
            4'd6:    return price[23:16];
            4'd7:    return price[15:8];
            4'd8:    return price[7:0];
            4'd9:    return LOT[15:8];
            4'd10:   return LOT[7:0];
            4'd11:   return csum;
            default: return 8'h00;
        endcase
    endfunction

    // Timestamp is captured for debug visibility only; reduce it so it has a sink
    assign unused_ts_s = ^timestamp_q;

    // Trading rule on the latched fields; buy wins when both sides qualify
    always_comb begin
        pos_s       = {{2{pos_q[15]}}, pos_q};
        buy_ok_s    = cfg_enable && (ask_q <= cfg_buy_limit) && ((pos_s + LOT_S) <= MAX_S);
        sell_ok_s   = cfg_enable && (bid_q >= cfg_sell_limit) && ((pos_s - LOT_S) >= -MAX_S);
        ord_side_s  = buy_ok_s ? SIDE_BUY : SIDE_SELL;
        ord_price_s = buy_ok_s ? ask_q : bid_q;
    end

    // Next-state, packet sequencing and counter logic
    always_comb begin
        state_d       = state_q;
        ticker_d      = ticker_q;
        timestamp_d   = timestamp_q;
        ask_d         = ask_q;
        bid_d         = bid_q;
        pos_d         = pos_q;
        side_d        = side_q;
        price_d       = price_q;
        csum_d        = csum_q;
        byte_idx_d    = byte_idx_q;
        tx_byte_d     = tx_byte_q;
        tx_valid_d    = tx_valid_q;
        tx_last_d     = tx_last_q;
        order_count_d = order_count_q;
        drop_count_d  = drop_count_q;

        case (state_q)
            IDLE: begin
                if (packet_ready) begin
                    ticker_d    = ticker;
                    timestamp_d = timestamp;
                    ask_d       = ask_cents;
                    bid_d       = bid_cents;
                    pos_d       = position;
                    state_d     = EVAL;
                end else begin
                    state_d = IDLE;
                end
            end
            EVAL: begin
                if (buy_ok_s || sell_ok_s) begin
                    side_d     = ord_side_s;
                    price_d    = ord_price_s;
                    csum_d     = calc_checksum(ord_side_s, ticker_q, ord_price_s);
                    byte_idx_d = 4'd0;
                    tx_byte_d  = HDR_BYTE;
                    tx_valid_d = 1'b1;
                    tx_last_d  = 1'b0;
                    state_d    = SEND;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                if (tx_valid_q && tx_ready) begin
                    if (byte_idx_q == LAST_IDX) begin
                        tx_valid_d    = 1'b0;
                        tx_last_d     = 1'b0;
                        tx_byte_d     = 8'h00;
                        order_count_d = order_count_q + 16'd1;
                        state_d       = IDLE;
                    end else begin
                        byte_idx_d = byte_idx_q + 4'd1;
                        tx_byte_d  = pkt_byte(byte_idx_q + 4'd1, side_q, ticker_q, price_q, csum_q);
                        tx_last_d  = ((byte_idx_q + 4'd1) == LAST_IDX);
                    end
                end else begin
                    state_d = SEND;
                end
            end
            default: begin
                state_d    = IDLE;
                tx_valid_d = 1'b0;
                tx_last_d  = 1'b0;
            end
        endcase

        if (packet_ready && (state_q != IDLE) && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end else begin
            drop_count_d = drop_count_d;
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ticker_q      <= 32'd0;
            timestamp_q   <= 32'd0;
            ask_q         <= 24'd0;
            bid_q         <= 24'd0;
            pos_q         <= 16'd0;
            side_q        <= 8'd0;
            price_q       <= 24'd0;
            csum_q        <= 8'd0;
            byte_idx_q    <= 4'd0;
            tx_byte_q     <= 8'd0;
            tx_valid_q    <= 1'b0;
            tx_last_q     <= 1'b0;
            busy_q        <= 1'b0;
            order_count_q <= 16'd0;
            drop_count_q  <= 16'd0;
        end else begin
            state_q       <= state_d;
            ticker_q      <= ticker_d;
            timestamp_q   <= timestamp_d;
            ask_q         <= ask_d;
            bid_q         <= bid_d;
            pos_q         <= pos_d;
            side_q        <= side_d;
            price_q       <= price_d;
            csum_q        <= csum_d;
            byte_idx_q    <= byte_idx_d;
            tx_byte_q     <= tx_byte_d;
            tx_valid_q    <= tx_valid_d;
            tx_last_q     <= tx_last_d;
            busy_q        <= busy_d;
            order_count_q <= order_count_d;
            drop_count_q  <= drop_count_d;
        end
    end

    assign tx_byte     = tx_byte_q;
    assign tx_valid    = tx_valid_q;
    assign tx_last     = tx_last_q;
    assign busy        = busy_q;
    assign order_count = order_count_q;
    assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_order_generator.sv
// Scoreboard bench for order_generator: expected bytes queued at stimulus time,
// compared on each tx handshake; counters checked against a small bench model.
module tb_order_generator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        packet_ready = 1'b0;
    logic [31:0] ticker = 32'd0;
    logic [31:0] timestamp = 32'd0;
    logic [23:0] ask_cents = 24'd0;
    logic [23:0] bid_cents = 24'd0;
    logic [15:0] position = 16'd0;
    logic        cfg_enable = 1'b0;
    logic [23:0] cfg_buy_limit = 24'd0;
    logic [23:0] cfg_sell_limit = 24'd0;
    logic        tx_ready = 1'b0;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_last;
    logic        busy;
    logic [15:0] order_count;
    logic [15:0] drop_count;

    typedef struct {
        logic [7:0] b;
        logic       last;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   m_orders = 0;
    int   m_drops = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_byte = 8'd0;

    localparam logic [31:0] AAPL = 32'h4141504C;
    localparam logic [31:0] MSFT = 32'h4D534654;

    order_generator dut (
        .clk(clk), .rst_n(rst_n), .packet_ready(packet_ready), .ticker(ticker),
        .timestamp(timestamp), .ask_cents(ask_cents), .bid_cents(bid_cents),
        .position(position), .cfg_enable(cfg_enable), .cfg_buy_limit(cfg_buy_limit),
        .cfg_sell_limit(cfg_sell_limit), .tx_byte(tx_byte), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_last(tx_last), .busy(busy),
        .order_count(order_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Handshake monitor: sampled on the falling edge, ahead of the posedge that commits it
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", {31'd0, tx_valid}, 32'd1);
                chk("hold_byte", {24'd0, tx_byte}, {24'd0, prev_byte});
            end
            if (tx_valid && tx_ready) begin
                chk("sb_has_entry", {31'd0, exp_q.size() > 0}, 32'd1);
                if (exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("tx_byte", {24'd0, tx_byte}, {24'd0, e.b});
                    chk("tx_last", {31'd0, tx_last}, {31'd0, e.last});
                end
            end
            prev_stall <= tx_valid && !tx_ready;
            prev_byte  <= tx_byte;
        end
    end

    function automatic int decide(input int ask, input int bid, input int pos);
        if (!cfg_enable) return 0;
        if (ask <= int'(cfg_buy_limit) && pos + 100 <= 1000) return 1;
        if (bid >= int'(cfg_sell_limit) && pos - 100 >= -1000) return 2;
        return 0;
    endfunction

    task automatic push_order(input logic [7:0] side, input logic [31:0] tk, input logic [23:0] pr);
        logic [7:0] b[12];
        b[0] = 8'hA5; b[1] = side;
        b[2] = tk[31:24]; b[3] = tk[23:16]; b[4] = tk[15:8]; b[5] = tk[7:0];
        b[6] = pr[23:16]; b[7] = pr[15:8]; b[8] = pr[7:0];
        b[9] = 8'h00; b[10] = 8'h64;
        b[11] = 8'h00;
        for (int i = 1; i <= 10; i++) b[11] = b[11] ^ b[i];
        for (int i = 0; i < 12; i++) exp_q.push_back('{b[i], (i == 11)});
    endtask

    // Drive one packet_ready pulse; returns at #1 after the edge that samples it
    task automatic send_pkt(input logic [31:0] tk, input int ask, input int bid, input int pos,
                            input bit use_model);
        int d;
        @(posedge clk); #1;
        ticker = tk; timestamp = $urandom; ask_cents = 24'(ask); bid_cents = 24'(bid);
        position = 16'(pos); packet_ready = 1'b1;
        if (use_model) begin
            d = decide(ask, bid, pos);
            if (d == 1) push_order(8'h42, tk, 24'(ask));
            else if (d == 2) push_order(8'h53, tk, 24'(bid));
            if (d != 0) m_orders++;
        end
        @(posedge clk); #1;
        packet_ready = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 300; k++) begin
            if (!busy && !tx_valid) break;
            @(posedge clk); #1;
        end
        chk("idle_reached", {31'd0, busy | tx_valid}, 32'd0);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic set_cfg(input logic en, input int bl, input int sl);
        cfg_enable = en; cfg_buy_limit = 24'(bl); cfg_sell_limit = 24'(sl);
    endtask

    initial begin
        logic [7:0] aapl_bytes[12];
        int k;
        int m_cnt;
        aapl_bytes = '{8'hA5, 8'h42, 8'h41, 8'h41, 8'h50, 8'h4C,
                       8'h00, 8'h3A, 8'h98, 8'h00, 8'h64, 8'h98};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_tx_last", {31'd0, tx_last}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_tx_byte", {24'd0, tx_byte}, 32'd0);
        chk("rst_order_count", {16'd0, order_count}, 32'd0);
        chk("rst_drop_count", {16'd0, drop_count}, 32'd0);
        rst_n = 1'b1;

        // Basic buy with literal expected bytes and latency
        tx_ready = 1'b1;
        set_cfg(1'b1, 15050, 20000);
        for (int i = 0; i < 12; i++) exp_q.push_back('{aapl_bytes[i], (i == 11)});
        m_orders++;
        send_pkt(AAPL, 15000, 14990, 0, 1'b0);
        chk("lat_eval_valid", {31'd0, tx_valid}, 32'd0);
        chk("lat_eval_busy", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        chk("lat_first_valid", {31'd0, tx_valid}, 32'd1);
        chk("lat_first_byte", {24'd0, tx_byte}, 32'hA5);
        wait_idle();
        chk("buy_order_count", {16'd0, order_count}, 32'd1);

        // Sell with backpressure pattern 1,0,0
        set_cfg(1'b1, 10000, 20000);
        tx_ready = 1'b0;
        send_pkt(MSFT, 20020, 20010, 0, 1'b1);
        for (k = 0; k < 100 && busy; k++) begin
            tx_ready = (k % 3 == 0);
            @(posedge clk); #1;
        end
        tx_ready = 1'b1;
        wait_idle();
        chk("sell_order_count", {16'd0, order_count}, 32'(m_orders));

        // Position limits and enable
        set_cfg(1'b1, 15050, 20000);
        send_pkt(AAPL, 15000, 14990, 901, 1'b1);
        chk("lim901_busy_eval", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        chk("lim901_busy_1cyc", {31'd0, busy}, 32'd0);
        chk("lim901_no_valid", {31'd0, tx_valid}, 32'd0);
        wait_idle();
        send_pkt(AAPL, 15000, 14990, 900, 1'b1);
        wait_idle();
        set_cfg(1'b1, 10000, 20000);
        send_pkt(AAPL, 20020, 20010, -901, 1'b1);
        wait_idle();
        send_pkt(AAPL, 20020, 20010, -900, 1'b1);
        wait_idle();
        set_cfg(1'b0, 15050, 20000);
        send_pkt(AAPL, 15000, 20010, 0, 1'b1);
        wait_idle();
        chk("limits_order_count", {16'd0, order_count}, 32'(m_orders));

        // Priority: both sides qualify
        set_cfg(1'b1, 15050, 20000);
        send_pkt(MSFT, 15000, 20010, 0, 1'b1);
        chk("prio_sb_side", {24'd0, exp_q[1].b}, 32'h42);
        wait_idle();

        // Drop while sending
        send_pkt(AAPL, 15000, 14990, 0, 1'b1);
        repeat (4) begin @(posedge clk); #1; end
        packet_ready = 1'b1;
        m_drops++;
        @(posedge clk); #1;
        packet_ready = 1'b0;
        chk("drop_mid_send", {16'd0, drop_count}, 32'(m_drops));
        wait_idle();
        chk("drop_order_count", {16'd0, order_count}, 32'(m_orders));

        // Back-to-back: new packet on the cycle after the final handshake
        send_pkt(AAPL, 15000, 14990, 0, 1'b1);
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (tx_valid && tx_last && tx_ready) break;
        end
        chk("b2b_saw_last", {31'd0, k < 100}, 32'd1);
        send_pkt(MSFT, 15000, 14990, 100, 1'b1);
        wait_idle();
        chk("b2b_no_drop", {16'd0, drop_count}, 32'(m_drops));
        chk("b2b_order_count", {16'd0, order_count}, 32'(m_orders));

        // Reset at byte_idx 5
        tx_ready = 1'b0;
        send_pkt(AAPL, 15000, 14990, 0, 1'b1);
        for (k = 0; k < 10 && !tx_valid; k++) begin @(posedge clk); #1; end
        tx_ready = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        tx_ready = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        m_orders = 0;
        m_drops = 0;
        chk("rstmid_valid", {31'd0, tx_valid}, 32'd0);
        chk("rstmid_orders", {16'd0, order_count}, 32'd0);
        chk("rstmid_drops", {16'd0, drop_count}, 32'd0);
        repeat (3) begin @(posedge clk); #1; end
        chk("rstmid_stays_quiet", {31'd0, tx_valid | busy}, 32'd0);
        tx_ready = 1'b1;
        send_pkt(MSFT, 14000, 14990, 0, 1'b1);
        wait_idle();
        chk("rstmid_next_order", {16'd0, order_count}, 32'd1);

        // Flood: packet_ready held high across repeated sends until drops saturate
        @(posedge clk); #1;
        packet_ready = 1'b1;
        ticker = AAPL; ask_cents = 24'd15000; bid_cents = 24'd14990; position = 16'd0;
        m_cnt = 0;
        for (int c = 0; c < 71000; c++) begin
            if (m_cnt == 0) begin
                push_order(8'h42, AAPL, 24'd15000);
                m_orders++;
                m_cnt = 13;
            end else begin
                if (m_drops < 65535) m_drops++;
                m_cnt--;
            end
            @(posedge clk);
        end
        #1;
        packet_ready = 1'b0;
        wait_idle();
        chk("flood_drop_sat", {16'd0, drop_count}, 32'hFFFF);
        chk("flood_drop_model", {16'd0, drop_count}, 32'(m_drops));
        chk("flood_order_count", {16'd0, order_count}, {16'd0, 16'(m_orders)});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
